// File: rtl/tcp_vlg_pkg.sv
// Shared TCP engine types: connection status, sequence numbers and the
// ACK-scheduler state encoding.
package tcp_vlg_pkg;

   typedef logic [31:0] tcp_num_t;

   typedef enum logic [2:0] {
      tcp_closed        = 3'd0,
      tcp_listening     = 3'd1,
      tcp_connecting    = 3'd2,
      tcp_connected     = 3'd3,
      tcp_disconnecting = 3'd4
   } tcp_stat_t;

   typedef enum logic [1:0] {
      idle_s = 2'd0,
      wait_s = 2'd1,
      req_s  = 2'd2
   } ack_ctl_fsm_t;

endpackage

// File: rtl/tcp_vlg_ack_ctl.sv
// Pure-ACK scheduler for one TCP connection: decides when the transmit
// arbiter must send an ACK (immediate, delayed, or after N in-order packets).
module tcp_vlg_ack_ctl
   import tcp_vlg_pkg::*;
#(
   parameter int TIMEOUT           = 1250,
   parameter int FORCE_ACK_PACKETS = 5
)(
   input  logic         clk,
   input  logic         rst,
   input  tcp_stat_t    status_i,
   input  logic         init_i,
   input  tcp_num_t     init_ack_i,
   input  tcp_num_t     loc_ack_i,
   input  logic         pkt_rx_i,
   input  logic         ooo_i,
   input  logic         sack_upd_i,
   input  logic         pb_val_i,
   input  tcp_num_t     pb_ack_i,
   output logic         send_req_o,
   input  logic         send_gnt_i,
   output tcp_num_t     ack_num_o,
   output logic         pending_o,
   output ack_ctl_fsm_t state_o
);

   localparam int CNT_W = $clog2(FORCE_ACK_PACKETS + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FORCE_ACK_PACKETS);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

   ack_ctl_fsm_t     state_q,    state_d;
   tcp_num_t         last_ack_q, last_ack_d;
   tcp_num_t         ack_num_q,  ack_num_d;
   logic [CNT_W-1:0] pkt_cnt_q,  pkt_cnt_d;
   logic [TMR_W-1:0] timer_q,    timer_d;
   logic             re_req_q,   re_req_d;
   logic             send_req_q, send_req_d;

   logic             connected_s;
   logic             event_s;
   logic             trigger_s;
   logic             pb_match_s;
   logic             rereq_now_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [CNT_W-1:0] cnt_fresh_s;

   assign connected_s = (status_i == tcp_connected);
   assign event_s     = sack_upd_i | ooo_i;
   assign trigger_s   = event_s | (pkt_cnt_q == CNT_MAX) | (timer_q == TMR_LAST);
   assign pb_match_s  = pb_val_i & (pb_ack_i == loc_ack_i);
   // Events coinciding with a grant feed straight into the next request.
   assign rereq_now_s = re_req_q | event_s;
   assign cnt_inc_s   = (pkt_rx_i && (pkt_cnt_q != CNT_MAX)) ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;
   assign cnt_fresh_s = pkt_rx_i ? CNT_W'(1) : CNT_W'(0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= idle_s;
         last_ack_q <= 32'd0;
         ack_num_q  <= 32'd0;
         pkt_cnt_q  <= '0;
         timer_q    <= '0;
         re_req_q   <= 1'b0;
         send_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ack_q <= last_ack_d;
         ack_num_q  <= ack_num_d;
         pkt_cnt_q  <= pkt_cnt_d;
         timer_q    <= timer_d;
         re_req_q   <= re_req_d;
         send_req_q <= send_req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (init_i || !connected_s) begin
         state_d = idle_s;
      end else begin
         case (state_q)
            idle_s: begin
               if (trigger_s)      state_d = req_s;
               else if (pending_o) state_d = wait_s;
               else                state_d = idle_s;
            end
            wait_s: begin
               if (pb_match_s)     state_d = idle_s;
               else if (trigger_s) state_d = req_s;
               else                state_d = wait_s;
            end
            req_s: begin
               if (send_gnt_i) begin
                  if (rereq_now_s)                  state_d = req_s;
                  else if (loc_ack_i != ack_num_q)  state_d = wait_s;
                  else                              state_d = idle_s;
               end else begin
                  state_d = req_s;
               end
            end
            default: state_d = idle_s;
         endcase
      end
   end

   always_comb begin
      last_ack_d = last_ack_q;
      ack_num_d  = ack_num_q;
      pkt_cnt_d  = cnt_inc_s;
      timer_d    = timer_q;
      re_req_d   = re_req_q;
      if (init_i) begin
         last_ack_d = init_ack_i;
         pkt_cnt_d  = '0;
         timer_d    = '0;
         re_req_d   = 1'b0;
      end else if (!connected_s) begin
         pkt_cnt_d  = '0;
         timer_d    = '0;
         re_req_d   = 1'b0;
      end else begin
         case (state_q)
            idle_s: begin
               timer_d = '0;
               if (trigger_s) ack_num_d = loc_ack_i;
               else           ack_num_d = ack_num_q;
            end
            wait_s: begin
               if (pb_match_s) begin
                  last_ack_d = pb_ack_i;
                  pkt_cnt_d  = cnt_fresh_s;
                  timer_d    = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
                  if (trigger_s) ack_num_d = loc_ack_i;
                  else           ack_num_d = ack_num_q;
               end
            end
            req_s: begin
               if (send_gnt_i) begin
                  last_ack_d = ack_num_q;
                  pkt_cnt_d  = cnt_fresh_s;
                  timer_d    = '0;
                  re_req_d   = 1'b0;
                  if (rereq_now_s) ack_num_d = loc_ack_i;
                  else             ack_num_d = ack_num_q;
               end else if (event_s) begin
                  re_req_d = 1'b1;
               end else begin
                  re_req_d = re_req_q;
               end
            end
            default: begin
               timer_d  = '0;
               re_req_d = 1'b0;
            end
         endcase
      end
   end

   assign send_req_d = (state_d == req_s);

   assign send_req_o = send_req_q;
   assign ack_num_o  = ack_num_q;
   assign pending_o  = (loc_ack_i != last_ack_q);
   assign state_o    = state_q;

endmodule

// File: tb/tb_tcp_vlg_ack_ctl.sv
// Directed test-plan scenarios plus randomized traffic, checked against a
// rule-level model of the ACK scheduler.
module tb_tcp_vlg_ack_ctl;
   import tcp_vlg_pkg::*;

   localparam int T_OUT = 20;
   localparam int F_PKT = 3;

   logic         clk = 1'b0;
   logic         rst;
   tcp_stat_t    status;
   logic         init;
   tcp_num_t     init_ack;
   tcp_num_t     loc_ack;
   logic         pkt_rx, ooo, sack_upd, pb_val, send_gnt;
   tcp_num_t     pb_ack;
   logic         send_req, pending;
   tcp_num_t     ack_num;
   ack_ctl_fsm_t state;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   ack_ctl_fsm_t m_phase;
   tcp_num_t     m_last, m_num;
   int           m_cnt, m_age;
   bit           m_rereq, m_req;

   tcp_vlg_ack_ctl #(.TIMEOUT(T_OUT), .FORCE_ACK_PACKETS(F_PKT)) dut (
      .clk(clk), .rst(rst), .status_i(status), .init_i(init), .init_ack_i(init_ack),
      .loc_ack_i(loc_ack), .pkt_rx_i(pkt_rx), .ooo_i(ooo), .sack_upd_i(sack_upd),
      .pb_val_i(pb_val), .pb_ack_i(pb_ack), .send_req_o(send_req), .send_gnt_i(send_gnt),
      .ack_num_o(ack_num), .pending_o(pending), .state_o(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      bit fire, ev;
      int cnt_n;
      ev    = sack_upd | ooo;
      cnt_n = (pkt_rx && m_cnt < F_PKT) ? m_cnt + 1 : m_cnt;
      fire  = ev || (m_cnt == F_PKT) || (m_age == T_OUT - 1);
      if (rst) begin
         m_phase = idle_s; m_last = 0; m_num = 0; m_cnt = 0; m_age = 0; m_rereq = 0;
      end else if (init) begin
         m_phase = idle_s; m_last = init_ack; m_cnt = 0; m_age = 0; m_rereq = 0;
      end else if (status != tcp_connected) begin
         m_phase = idle_s; m_cnt = 0; m_age = 0; m_rereq = 0;
      end else begin
         m_cnt = cnt_n;
         if (m_phase == idle_s) begin
            m_age = 0;
            if (fire) begin m_phase = req_s; m_num = loc_ack; end
            else if (loc_ack != m_last) m_phase = wait_s;
         end else if (m_phase == wait_s) begin
            if (pb_val && pb_ack == loc_ack) begin
               m_last = pb_ack; m_cnt = pkt_rx ? 1 : 0; m_age = 0; m_phase = idle_s;
            end else begin
               m_age = m_age + 1;
               if (fire) begin m_phase = req_s; m_num = loc_ack; end
            end
         end else begin
            if (send_gnt) begin
               m_last = m_num; m_cnt = pkt_rx ? 1 : 0; m_age = 0;
               if (m_rereq || ev) m_num = loc_ack;
               else if (loc_ack != m_num) m_phase = wait_s;
               else m_phase = idle_s;
               m_rereq = 0;
            end else if (ev) begin
               m_rereq = 1;
            end
         end
      end
      m_req = (m_phase == req_s);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("send_req", 32'(send_req), 32'(m_req));
      chk("ack_num", ack_num, m_num);
      chk("state", 32'(state), 32'(m_phase));
      chk("pending", 32'(pending), 32'(loc_ack != m_last));
   endtask

   task automatic quiet();
      rst = 0; init = 0; pkt_rx = 0; ooo = 0; sack_upd = 0; pb_val = 0; send_gnt = 0;
   endtask

   initial begin
      int n;
      status = tcp_connected; init_ack = 0; loc_ack = 0; pb_ack = 0;
      quiet();
      rst = 1;
      tick(); tick();
      rst = 0;
      tick();
      chk("rst_req", 32'(send_req), 32'd0);
      chk("rst_num", ack_num, 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_state", 32'(state), 32'(idle_s));

      // delayed ACK
      init = 1; init_ack = 32'h100; loc_ack = 32'h100; tick(); init = 0;
      loc_ack = 32'h140;
      n = 0;
      for (int i = 0; i < 60 && !send_req; i++) begin tick(); n++; end
      chk("dly_lat", 32'(n), 32'd21);
      chk("dly_num", ack_num, 32'h140);
      send_gnt = 1; tick(); send_gnt = 0;
      chk("dly_req", 32'(send_req), 32'd0);
      chk("dly_pend", 32'(pending), 32'd0);
      chk("dly_state", 32'(state), 32'(idle_s));

      // forced by packet count
      for (int p = 0; p < 3; p++) begin
         loc_ack = loc_ack + 32'h10; pkt_rx = 1; tick(); pkt_rx = 0;
         if (p < 2) tick();
      end
      tick();
      chk("frc_req", 32'(send_req), 32'd1);
      chk("frc_num", ack_num, 32'h170);
      send_gnt = 1; tick(); send_gnt = 0;

      // ooo immediate, sack re-request
      loc_ack = 32'h180; tick(); tick();
      ooo = 1; tick(); ooo = 0;
      chk("ooo_req", 32'(send_req), 32'd1);
      sack_upd = 1; tick(); sack_upd = 0;
      loc_ack = 32'h190; send_gnt = 1; tick(); send_gnt = 0;
      chk("rrq_req", 32'(send_req), 32'd1);
      chk("rrq_num", ack_num, 32'h190);
      send_gnt = 1; tick(); send_gnt = 0;
      chk("rrq_done", 32'(send_req), 32'd0);

      // piggyback
      loc_ack = 32'h200; tick(); tick();
      pb_val = 1; pb_ack = 32'h200; tick(); pb_val = 0;
      chk("pb_state", 32'(state), 32'(idle_s));
      chk("pb_pend", 32'(pending), 32'd0);
      loc_ack = 32'h210; tick();
      pb_val = 1; pb_ack = 32'h1F0; tick(); pb_val = 0;
      chk("pb_miss", 32'(state), 32'(wait_s));
      for (int i = 0; i < 60 && !send_req; i++) tick();
      chk("pb_tmo", 32'(send_req), 32'd1);
      send_gnt = 1; tick(); send_gnt = 0;

      // wrap-around
      init = 1; init_ack = 32'hFFFF_FFF0; tick(); init = 0;
      loc_ack = 32'h10; ooo = 1; tick(); ooo = 0;
      chk("wrap_num", ack_num, 32'h10);
      send_gnt = 1; tick(); send_gnt = 0;
      chk("wrap_pend", 32'(pending), 32'd0);

      // disconnect mid-request, then reset mid-wait
      loc_ack = 32'h20; ooo = 1; tick(); ooo = 0;
      status = tcp_closed; tick();
      chk("dis_req", 32'(send_req), 32'd0);
      chk("dis_pend", 32'(pending), 32'd1);
      status = tcp_connected;
      loc_ack = 32'h30; tick(); tick();
      rst = 1; loc_ack = 32'h0; tick(); rst = 0;
      chk("rw_req", 32'(send_req), 32'd0);
      chk("rw_num", ack_num, 32'd0);
      chk("rw_state", 32'(state), 32'(idle_s));
      chk("rw_pend", 32'(pending), 32'd0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         quiet();
         rst      = ($urandom % 500) == 0;
         init     = ($urandom % 200) == 0;
         init_ack = $urandom;
         status   = (($urandom % 80) == 0) ? tcp_closed : tcp_connected;
         if (($urandom % 6) == 0) loc_ack = loc_ack + 32'($urandom_range(1, 200));
         pkt_rx   = ($urandom % 5) == 0;
         ooo      = ($urandom % 120) == 0;
         sack_upd = ($urandom % 120) == 0;
         pb_val   = ($urandom % 12) == 0;
         pb_ack   = ($urandom % 2) ? loc_ack : loc_ack - 32'd1;
         send_gnt = m_req ? (($urandom % 3) == 0) : (($urandom % 25) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tcp_vlg_ack_ctl.md
# tcp_vlg_ack_ctl

Schedules pure-ACK transmissions for one TCP connection. It watches the receive path's local acknowledgement number, SACK-change and out-of-order events, then decides when the transmit engine must emit an ACK: immediately, after a delayed-ACK timeout, or after N unacknowledged in-order packets. It sits between the SACK/receive-queue logic and the TCP transmit arbiter, and talks to the arbiter through a req/gnt handshake.

## Interface
- TIMEOUT, 1250: delayed-ACK timeout, in clk cycles (≥2).
- FORCE_ACK_PACKETS, 5: number of in-order payload packets that forces an immediate ACK (≥1).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- status  in  tcp_stat_t  connection state; the block is active only when status is tcp_connected.
- init  in  1  one-cycle pulse that loads last_ack from init_ack.
- init_ack  in  32  initial local ack taken from the TCB.
- loc_ack  in  32  current local ack from the SACK logic.
- pkt_rx  in  1  pulse when an in-order payload packet is accepted.
- ooo  in  1  pulse when an out-of-order or duplicate segment is received.
- sack_upd  in  1  pulse when the reported SACK option changes.
- pb_val  in  1  pulse when the transmit engine sent a data segment carrying an ACK.
- pb_ack  in  32  ack number carried by that segment.
- send_req  out  1  pure-ACK request to the transmit arbiter.
- send_gnt  in  1  arbiter accepted the request (one-cycle pulse).
- ack_num  out  32  ack number to transmit; stable while send_req is high.
- pending  out  1  loc_ack differs from the last transmitted ack.

## Operation
- Registers:
  - last_ack (32): last transmitted ack.
  - pkt_cnt: width $clog2(FORCE_ACK_PACKETS+1).
  - timer: width $clog2(TIMEOUT+1).
  - re_req: 1 bit.
- pending = (loc_ack != last_ack), combinational.
- trigger = sack_upd | ooo | (pkt_cnt == FORCE_ACK_PACKETS) | (timer == TIMEOUT-1).
- FSM states: idle_s, wait_s, req_s.
- idle_s:
  - timer=0.
  - If trigger goes to req_s. Otherwise, if pending, goes to wait_s.
- wait_s:
  - timer increments each cycle.
  - Goes to req_s on trigger.
  - On pb_val with pb_ack==loc_ack: last_ack←pb_ack, pkt_cnt←0, timer←0, go to idle_s.
- req_s:
  - On entry, latch ack_num←loc_ack. send_req=1.
  - pb_val is ignored; a duplicate ACK is harmless.
  - sack_upd or ooo sets re_req.
  - On send_gnt:
    - last_ack←ack_num, pkt_cnt←0, timer←0.
    - If re_req: clear re_req, relatch ack_num←loc_ack, stay in req_s with send_req held.
    - Else if loc_ack≠ack_num: go to wait_s.
    - Else: go to idle_s.
- pkt_rx increments pkt_cnt in all states, saturating at FORCE_ACK_PACKETS.
- Priority when events coincide in one cycle:
  1. rst
  2. init
  3. status≠tcp_connected
  4. send_gnt
  5. pb_val
  6. trigger
- init: last_ack←init_ack, counters←0, re_req←0, state←idle_s.
- status≠tcp_connected: state←idle_s, send_req←0, counters←0, re_req←0; last_ack keeps its value.
- Arithmetic is 32-bit modulo. Comparisons are equality only, so sequence wrap-around is transparent.

## Timing
- Reset values: send_req=0, ack_num=0, last_ack=0, pkt_cnt=0, timer=0, re_req=0, state=idle_s.
- pending follows loc_ack and last_ack combinationally, so it reads 0 while both are 0 after reset.
- send_req and ack_num are registered. send_req rises the cycle after the trigger is sampled.
- Delayed-ACK latency: send_req rises exactly TIMEOUT cycles after the first cycle spent in wait_s.
- send_req drops the cycle after send_gnt, except on a re_req re-request, where it stays high.
- send_gnt seen while send_req=0 is ignored.
- An event in the same cycle as send_gnt counts toward the next request.

## Structure
- tcp_stat_t and tcp_num_t come from tcp_vlg_pkg.
- Add to tcp_vlg_pkg an ack_ctl_fsm_t enum for the three states, exported for bench visibility.
- No sub-module: the timer and counter stay inline. The block is instantiated beside tcp_vlg_sack in the TCP engine top.

## Test plan
- Delayed ACK: TIMEOUT=20, init_ack=0x100, loc_ack→0x140 at cycle 0, no other events → send_req rises at cycle 21 with ack_num=0x140; gnt → pending=0, state idle_s.
- Force count: FORCE_ACK_PACKETS=3, three pkt_rx pulses 2 cycles apart while loc_ack advances → send_req one cycle after the third pulse, well before the timeout.
- SACK/OOO immediate: ooo pulse in wait_s → send_req next cycle. sack_upd held during req_s → after gnt, send_req stays high with the relatched ack_num.
- Piggyback: loc_ack=0x200, pb_val with pb_ack=0x200 in wait_s → idle_s, no send_req. Same pulse with pb_ack=0x1F0 → timer keeps running.
- Wrap: init_ack=0xFFFFFFF0, loc_ack=0x00000010 → ACK sent with ack_num=0x00000010, pending clears.
- Disconnect mid-request: status leaves tcp_connected while send_req=1 → send_req=0 next cycle, last_ack unchanged; rst mid-wait → all outputs return to their reset values.
